synaptic_integrator: RTL

- Time-multiplexed synapse stage that directly feeds a LIF neuron's `current` input. It produces the drive for the second neuron, whose current input is otherwise unconnected.
- On each frame tick it samples N presynaptic spikes, for example the `spike` output of the first neuron plus external spike lines.
- It scans them one per cycle through a shared signed-weight adder.
- It then folds the weighted sum into a leaky, saturating 8-bit current register presented to the neuron.

---
 rtl/snn_pkg.sv | 34 +++
 rtl/synapse_weight_rf.sv | 55 +++++
 rtl/synaptic_integrator.sv | 129 ++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared types, widths and helpers for the spiking-neuron path:
//                current width, default weight width, the synapse FSM
//                state encoding and an unsigned 8-bit saturation helper.
//  Revision    : 1.0
// ============================================================================
package snn_pkg;

  localparam int CUR_WIDTH   = 8;
  localparam int W_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  // Clamp a signed quantity into the unsigned 0..255 current range.
  function automatic logic [CUR_WIDTH-1:0] sat_u8(input logic signed [31:0] v);
    logic [CUR_WIDTH-1:0] r;
    if (v < 32'sd0) begin
      r = '0;
    end else if (v > 32'sd255) begin
      r = '1;
    end else begin
      r = v[CUR_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synapse_weight_rf.sv
`default_nettype none
// ============================================================================
//  Module      : synapse_weight_rf
//  Description : N_INPUTS x W_WIDTH synaptic weight register file. One
//                synchronous write port, one combinational read port,
//                asynchronous reset clears every weight to zero.
//  Revision    : 1.0
// ============================================================================
module synapse_weight_rf #(
  parameter int N_INPUTS = 4,
  parameter int W_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr,
  input  logic [W_WIDTH-1:0]          wr_data,
  input  logic [$clog2(N_INPUTS)-1:0] rd_addr,
  output logic [W_WIDTH-1:0]          rd_data
);

  localparam int IDX_W = $clog2(N_INPUTS);
  // One extra bit so the entry count itself is representable for bounds checks.
  localparam logic [IDX_W:0] C_N = (IDX_W+1)'(N_INPUTS);

  logic [W_WIDTH-1:0] mem_q [N_INPUTS];

  logic wr_ok;
  logic rd_ok;

  // Addresses beyond the populated entries exist only when N_INPUTS is not a power of two.
  assign wr_ok = ({1'b0, wr_addr} < C_N);
  assign rd_ok = ({1'b0, rd_addr} < C_N);

  // Weight storage: cleared on reset, written one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read port sees the stored value, so a same-cycle write is not forwarded.
  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/synaptic_integrator.sv
`default_nettype none
// ============================================================================
//  Module      : synaptic_integrator
//  Description : Time-multiplexed synapse stage. On a frame tick it latches
//                the presynaptic spikes, scans them one per cycle through a
//                shared signed-weight adder, then folds the sum into a leaky,
//                saturating 8-bit current that drives a LIF neuron.
//  Revision    : 1.0
// ============================================================================
module synaptic_integrator
  import snn_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int W_WIDTH     = W_WIDTH_DEF,
  parameter int DECAY_SHIFT = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tick,
  input  logic [N_INPUTS-1:0]         spike_in,
  input  logic                        wr_en,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr,
  input  logic [W_WIDTH-1:0]          wr_data,
  output logic [CUR_WIDTH-1:0]        current,
  output logic                        current_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IDX_W = $clog2(N_INPUTS);
  // Wide enough that neither the weighted sum nor current+sum can wrap.
  localparam int ACC_W = CUR_WIDTH + W_WIDTH + IDX_W;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_INPUTS - 1);

  state_t                    state_q;
  logic [N_INPUTS-1:0]       spike_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic [IDX_W-1:0]          idx_q;
  logic [CUR_WIDTH-1:0]      current_q;
  logic [CUR_WIDTH-1:0]      current_d;
  logic                      current_valid_q;
  logic                      overrun_q;

  logic [W_WIDTH-1:0]        weight_rd;
  logic [CUR_WIDTH-1:0]      leaked;
  logic signed [ACC_W-1:0]   next_sum;

  synapse_weight_rf #(
    .N_INPUTS (N_INPUTS),
    .W_WIDTH  (W_WIDTH)
  ) u_weight_rf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_q),
    .rd_data (weight_rd)
  );

  // Shared adder: add the sign-extended weight of the scanned input if it spiked.
  always_comb begin
    acc_d = acc_q;
    if (spike_q[idx_q]) begin
      acc_d = acc_q + ACC_W'($signed(weight_rd));
    end
  end

  // Leak the held current, add the frame's weighted sum, clamp to 0..255.
  always_comb begin
    leaked    = current_q - (current_q >> DECAY_SHIFT);
    next_sum  = $signed({{(ACC_W-CUR_WIDTH){1'b0}}, leaked}) + acc_q;
    current_d = sat_u8(32'(next_sum));
  end

  // Frame sequencer: IDLE waits for tick, SCAN walks the inputs, UPDATE commits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      spike_q         <= '0;
      acc_q           <= '0;
      idx_q           <= '0;
      current_q       <= '0;
      current_valid_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      current_valid_q <= 1'b0;
      // A tick is only accepted from IDLE; anything else is a sticky overrun.
      if (tick && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            spike_q <= spike_in;
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          acc_q <= acc_d;
          if (idx_q == C_LAST) begin
            idx_q   <= '0;
            state_q <= UPDATE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        UPDATE: begin
          current_q       <= current_d;
          current_valid_q <= 1'b1;
          state_q         <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign current       = current_q;
  assign current_valid = current_valid_q;
  assign busy          = (state_q != IDLE);
  assign overrun       = overrun_q;

endmodule
`default_nettype wire
